// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path (and, later, the UART transmitter).
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} uart_rx_state_e;

  localparam int UART_DATA_BITS = 8;

  // Clocks per oversample tick, rounded to nearest and never below one.
  function automatic int uart_div(input int clk_hz, input int baud, input int os);
    int d;
    d = (clk_hz + (baud * os) / 2) / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable so a new
// frame starts on a fresh tick phase.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (restart || cnt == LAST)  cnt <= '0;
    else                              cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver, 16x oversampled, with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add a parity bit check (PARITY_ODD, parity_err).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                      parity_err
`endif
);

  localparam int DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(UART_DATA_BITS);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END    = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

  logic                      rx_meta, rx_s;
  uart_rx_state_e            state, state_n;
  logic [SW-1:0]             sample_cnt, sample_cnt_n;
  logic [BW-1:0]             bit_idx, bit_idx_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic                      tick, restart, stop_ok, stop_bad, parity_ok, deliver;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_bit_n;
  localparam uart_rx_state_e AFTER_DATA = PARITY;
  assign parity_ok = ((^{par_bit, shreg}) == PARITY_ODD);
`else
  localparam uart_rx_state_e AFTER_DATA = STOP;
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      sample_cnt <= sample_cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_bit_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    sample_cnt_n = sample_cnt;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    restart      = 1'b0;
    stop_ok      = 1'b0;
    stop_bad     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n    = par_bit;
`endif
    case (state)
      IDLE: if (!rx_s) begin
        state_n      = START;
        sample_cnt_n = '0;
        restart      = 1'b1;
      end
      // A start bit that is no longer low at mid-bit is treated as line noise.
      START: if (tick) begin
        if (sample_cnt == S_MID) begin
          sample_cnt_n = '0;
          bit_idx_n    = '0;
          state_n      = rx_s ? IDLE : DATA;
        end else sample_cnt_n = sample_cnt + 1'b1;
      end
      DATA: if (tick) begin
        if (sample_cnt == S_END) begin
          sample_cnt_n = '0;
          shreg_n      = {rx_s, shreg[UART_DATA_BITS-1:1]};
          if (bit_idx == LAST_BIT) state_n = AFTER_DATA;
          else bit_idx_n = bit_idx + 1'b1;
        end else sample_cnt_n = sample_cnt + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        if (sample_cnt == S_END) begin
          sample_cnt_n = '0;
          par_bit_n    = rx_s;
          state_n      = STOP;
        end else sample_cnt_n = sample_cnt + 1'b1;
      end
`endif
      STOP: if (tick) begin
        if (sample_cnt == S_END) begin
          sample_cnt_n = '0;
          stop_ok      = rx_s;
          stop_bad     = !rx_s;
          state_n      = rx_s ? IDLE : WAIT_HIGH;
        end else sample_cnt_n = sample_cnt + 1'b1;
      end
      WAIT_HIGH: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign deliver = stop_ok && parity_ok;

  // A completed byte only displaces the held one if it is being consumed this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= stop_bad;
      overrun   <= deliver && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
      parity_err <= (stop_ok || stop_bad) && !parity_ok;
`endif
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit (CLK_HZ=1.6 MHz, BAUD=100 kbit/s).
module tb_uart_rx;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int OS     = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Stop-bit mid-sample cycle counted from the start-bit falling edge.
  localparam int STOP_TICK = 2 + 8 + (9 + PAR_BITS) * OS;

  logic       clk = 1'b0;
  logic       rst, rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int tests_run = 0, tests_failed = 0;
  int cyc = 0, start_cyc = 0;
  int valid_cycles, fe_count, ov_count, pe_count, busy_cycles, first_valid_cyc;
  logic [7:0] last_data;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        valid_cycles = valid_cycles + 1;
        last_data    = rx_data;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      fe_count    = fe_count + int'(frame_err);
      ov_count    = ov_count + int'(overrun);
      busy_cycles = busy_cycles + int'(busy);
`ifdef UART_RX_PARITY_EN
      pe_count    = pe_count + int'(parity_err);
`endif
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run = tests_run + 1;
    if (observed !== expected) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearCounts();
    valid_cycles = 0; fe_count = 0; ov_count = 0; pe_count = 0;
    busy_cycles = 0; first_valid_cyc = -1; last_data = 8'h00;
  endtask

  task automatic driveBit(input logic b);
    rx = b;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic par_bit);
    @(posedge clk); #1;
    start_cyc = cyc;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    if (PAR_BITS == 1) driveBit(par_bit);
    driveBit(stop_bit);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    clearCounts();
    #22;
    checkOutput("por_outputs", int'({rx_data, rx_valid, frame_err, overrun, busy}), 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(4);

    // Plain byte with consumer always ready
    rx_ready = 1'b1;
    clearCounts();
    applyStimulus(8'hA5, 1'b1, 1'b0);
    idle(8);
    checkOutput("a5_data", int'(last_data), 8'hA5);
    checkOutput("a5_valid_cycles", valid_cycles, 1);
    checkOutput("a5_latency", first_valid_cyc - start_cyc, STOP_TICK + 1);
    checkOutput("a5_frame_err", fe_count, 0);
    checkOutput("a5_overrun", ov_count, 0);

    // Short low glitch on an idle line
    clearCounts();
    @(posedge clk); #1; rx = 1'b0;
    idle(4); rx = 1'b1;
    idle(40);
    checkOutput("glitch_busy_le10", int'(busy_cycles <= 10), 1);
    checkOutput("glitch_busy_seen", int'(busy_cycles > 0), 1);
    checkOutput("glitch_valid", valid_cycles, 0);
    checkOutput("glitch_frame_err", fe_count, 0);
    checkOutput("glitch_busy_end", int'(busy), 0);

    // Bad stop bit followed by a long break, then a clean byte
    clearCounts();
    applyStimulus(8'h3C, 1'b0, 1'b0);
    idle(40 * OS);
    rx = 1'b1;
    idle(3 * OS);
    checkOutput("break_frame_err", fe_count, 1);
    checkOutput("break_valid", valid_cycles, 0);
    clearCounts();
    applyStimulus(8'h81, 1'b1, 1'b0);
    idle(8);
    checkOutput("after_break_data", int'(last_data), 8'h81);
    checkOutput("after_break_valid_cycles", valid_cycles, 1);

    // Consumer stalled: second byte must be dropped
    rx_ready = 1'b0;
    clearCounts();
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    idle(8);
    checkOutput("stall_data", int'(rx_data), 8'h11);
    checkOutput("stall_overrun", ov_count, 1);
    checkOutput("stall_valid", int'(rx_valid), 1);
    rx_ready = 1'b1; idle(1); rx_ready = 1'b0;
    idle(1);
    checkOutput("consume_valid", int'(rx_valid), 0);

    // Consumer accepts in the very cycle the next byte completes
    applyStimulus(8'h11, 1'b1, 1'b0);
    idle(4);
    clearCounts();
    fork
      applyStimulus(8'h22, 1'b1, 1'b0);
      begin
        @(posedge clk); #1;
        repeat (STOP_TICK) @(posedge clk);
        #1; rx_ready = 1'b1;
        @(posedge clk); #1; rx_ready = 1'b0;
      end
    join
    idle(8);
    checkOutput("same_cycle_data", int'(rx_data), 8'h22);
    checkOutput("same_cycle_overrun", ov_count, 0);
    checkOutput("same_cycle_valid", int'(rx_valid), 1);

    // Reset in the middle of a frame while a byte is held
    @(posedge clk); #1;
    driveBit(1'b0);
    driveBit(1'b0); driveBit(1'b1); driveBit(1'b0);
    rst = 1'b1; rx = 1'b1;
    #2;
    checkOutput("mid_reset_outputs", int'({rx_data, rx_valid, frame_err, overrun, busy}), 0);
    idle(3);
    rst = 1'b0; rx_ready = 1'b1;
    clearCounts();
    applyStimulus(8'h5A, 1'b1, 1'b0);
    idle(8);
    checkOutput("post_reset_data", int'(last_data), 8'h5A);
    checkOutput("post_reset_valid_cycles", valid_cycles, 1);
    checkOutput("post_reset_frame_err", fe_count, 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the parity bit must be 1
    clearCounts();
    applyStimulus(8'h07, 1'b1, 1'b1);
    idle(8);
    checkOutput("par_good_data", int'(last_data), 8'h07);
    checkOutput("par_good_valid_cycles", valid_cycles, 1);
    checkOutput("par_good_err", pe_count, 0);
    clearCounts();
    applyStimulus(8'h07, 1'b1, 1'b0);
    idle(8);
    checkOutput("par_bad_err", pe_count, 1);
    checkOutput("par_bad_valid", valid_cycles, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
